core_bus_arbiter: RTL and testbench

//  Merges the core's instruction-fetch and data-memory master ports onto one memory-side port.

---
 rtl/core_bus_arbiter_if.sv | 50 +++++
 rtl/core_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_core_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_arbiter_if.sv
// Bundles the fetch port, data port and memory-side port of core_bus_arbiter.
// slave = the arbiter's view; master = the core and memory it sits between.
interface core_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              i_req_valid;
    logic              i_req_ready;
    logic [AW-1:0]     i_addr;
    logic              i_rsp_valid;
    logic [DW-1:0]     i_rsp_rdata;
    logic              i_rsp_err;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [AW-1:0]     d_addr;
    logic              d_we;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic              d_rsp_valid;
    logic [DW-1:0]     d_rsp_rdata;
    logic              d_rsp_err;

    logic              m_req_valid;
    logic              m_req_ready;
    logic [AW-1:0]     m_addr;
    logic              m_we;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_be;
    logic              m_rsp_valid;
    logic [DW-1:0]     m_rsp_rdata;

    modport slave (
        input  i_req_valid, i_addr,
        input  d_req_valid, d_addr, d_we, d_wdata, d_be,
        input  m_req_ready, m_rsp_valid, m_rsp_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        output m_req_valid, m_addr, m_we, m_wdata, m_be
    );

    modport master (
        output i_req_valid, i_addr,
        output d_req_valid, d_addr, d_we, d_wdata, d_be,
        output m_req_ready, m_rsp_valid, m_rsp_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        input  m_req_valid, m_addr, m_we, m_wdata, m_be
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// Merges the core's fetch (I) and data (D) ports onto one memory port, one transaction in flight.
// Optional response timeout with late-response discard: define BUS_TIMEOUT_EN.
module core_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    core_bus_arbiter_if.slave bus
);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef enum logic {OWN_D, OWN_I} owner_e;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } req_t;

    state_e     state, state_nxt;
    owner_e     owner;
    req_t       req_q;
    logic [1:0] streak;
    logic       grant_d, grant_i;
    logic       rsp_fire, tmo_fire;
    logic       timeout_hit;
    logic       orphan;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT) && (int'(wait_cnt) >= TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            orphan   <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT && state_nxt == WAIT) ? wait_cnt + 1'b1 : '0;
            // A timed-out transaction still owes one response; swallow it when it shows up.
            if (tmo_fire)
                orphan <= 1'b1;
            else if (bus.m_rsp_valid && orphan)
                orphan <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign orphan      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        rsp_fire  = 1'b0;
        tmo_fire  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    // Data wins, except after two straight wins over a waiting fetch.
                    if (bus.d_req_valid && !(streak == 2'd2 && bus.i_req_valid))
                        grant_d = 1'b1;
                    else if (bus.i_req_valid)
                        grant_i = 1'b1;
                    if (grant_d || grant_i)
                        state_nxt = ISSUE;
                end
                ISSUE: if (bus.m_req_ready) state_nxt = WAIT;
                WAIT: begin
                    if (bus.m_rsp_valid && !orphan) begin
                        rsp_fire  = 1'b1;
                        state_nxt = IDLE;
                    end else if (timeout_hit) begin
                        tmo_fire  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.d_req_ready = grant_d;
        bus.i_req_ready = grant_i;
        bus.m_req_valid = !rst && (state == ISSUE);
        bus.m_addr      = req_q.addr;
        bus.m_we        = req_q.we;
        bus.m_wdata     = req_q.wdata;
        bus.m_be        = req_q.be;
        bus.d_rsp_valid = (rsp_fire || tmo_fire) && (owner == OWN_D);
        bus.i_rsp_valid = (rsp_fire || tmo_fire) && (owner == OWN_I);
        bus.d_rsp_rdata = (rsp_fire && owner == OWN_D) ? bus.m_rsp_rdata : '0;
        bus.i_rsp_rdata = (rsp_fire && owner == OWN_I) ? bus.m_rsp_rdata : '0;
        bus.d_rsp_err   = tmo_fire && (owner == OWN_D);
        bus.i_rsp_err   = tmo_fire && (owner == OWN_I);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= OWN_D;
            streak <= 2'd0;
            req_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                owner <= OWN_D;
                req_q <= '{addr: bus.d_addr, we: bus.d_we, wdata: bus.d_wdata, be: bus.d_be};
            end else if (grant_i) begin
                owner <= OWN_I;
                req_q <= '{addr: bus.i_addr, we: 1'b0, wdata: '0, be: '1};
            end
            if (grant_i || !bus.i_req_valid)
                streak <= 2'd0;
            else if (grant_d && streak != 2'd3)
                streak <= streak + 2'd1;
        end
    end

    rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        (bus.m_rsp_valid && !orphan) |-> (state == WAIT));
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Randomized self-checking bench for core_bus_arbiter with a transaction-level reference model.
// Timeout scenario runs only when BUS_TIMEOUT_EN is defined.
module tb_core_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    core_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    core_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.i_req_valid = 1'b0; bus.i_addr = '0;
        bus.d_req_valid = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0; bus.d_wdata = '0; bus.d_be = '0;
        bus.m_req_ready = 1'b0; bus.m_rsp_valid = 1'b0; bus.m_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        bus.i_req_valid = 1'b1; bus.d_req_valid = 1'b1; bus.d_addr = 32'h3000_0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if ({bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid, bus.m_req_valid,
                 bus.i_rsp_err, bus.d_rsp_err} !== 7'b0 || bus.m_addr !== '0 || bus.d_rsp_rdata !== '0)
                begin bad++; $display("FAIL reset_outputs cyc=%0d got rdy=%b%b vld=%b%b%b m_addr=%h want all 0",
                    c, bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid, bus.m_req_valid, bus.m_addr); end
            @(negedge clk);
        end
        rst = 1'b0; #1;
        total++;
        if (bus.d_req_ready !== 1'b1 || bus.i_req_ready !== 1'b0)
            begin bad++; $display("FAIL reset_first_accept got d=%b i=%b want d=1 i=0", bus.d_req_ready, bus.i_req_ready); end
        @(negedge clk); bus.d_req_valid = 1'b0; bus.i_req_valid = 1'b0; #1;
        total++;
        if (bus.m_req_valid !== 1'b1 || bus.m_addr !== 32'h3000_0000)
            begin bad++; $display("FAIL reset_first_issue got v=%b a=%h want v=1 a=30000000", bus.m_req_valid, bus.m_addr); end
    endtask

    task automatic test_single_fetch();
        do_reset();
        bus.i_addr = 32'h1000_0000; bus.i_req_valid = 1'b1; bus.m_req_ready = 1'b1; #1;
        total++;
        if (bus.i_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0)
            begin bad++; $display("FAIL fetch_ready got i=%b d=%b want i=1 d=0", bus.i_req_ready, bus.d_req_ready); end
        @(negedge clk); bus.i_req_valid = 1'b0; bus.i_addr = '0; #1;
        total++;
        if (bus.m_req_valid !== 1'b1 || bus.m_addr !== 32'h1000_0000 || bus.m_we !== 1'b0 || bus.m_be !== 4'hF)
            begin bad++; $display("FAIL fetch_issue got v=%b a=%h we=%b be=%h want 1 10000000 0 f",
                bus.m_req_valid, bus.m_addr, bus.m_we, bus.m_be); end
        @(negedge clk); bus.m_req_ready = 1'b0; bus.m_rsp_valid = 1'b1; bus.m_rsp_rdata = 32'h0000_0013; #1;
        total++;
        if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_rdata !== 32'h13 || bus.i_rsp_err !== 1'b0 || bus.d_rsp_valid !== 1'b0)
            begin bad++; $display("FAIL fetch_rsp got iv=%b rd=%h err=%b dv=%b want 1 00000013 0 0",
                bus.i_rsp_valid, bus.i_rsp_rdata, bus.i_rsp_err, bus.d_rsp_valid); end
        @(negedge clk); bus.m_rsp_valid = 1'b0; #1;
        total++;
        if (bus.i_rsp_valid !== 1'b0 || bus.i_rsp_rdata !== '0 || bus.m_req_valid !== 1'b0)
            begin bad++; $display("FAIL fetch_after got iv=%b rd=%h mv=%b want 0 0 0",
                bus.i_rsp_valid, bus.i_rsp_rdata, bus.m_req_valid); end
    endtask

    task automatic test_collision();
        int g = 0;
        int cyc = 0;
        logic own_i = 1'b0;
        logic [AW-1:0] exp_addr = '0;
        logic mem_busy = 1'b0;
        do_reset();
        bus.d_req_valid = 1'b1; bus.i_req_valid = 1'b1; bus.m_req_ready = 1'b1; bus.d_be = '1;
        while (g < 12 && cyc < 100) begin
            bus.d_addr = 32'hD000_0000 + g; bus.i_addr = 32'h1000_0000 + g;
            bus.m_rsp_valid = mem_busy; bus.m_rsp_rdata = $urandom;
            #1;
            if (mem_busy) begin
                total++;
                if (bus.i_rsp_valid !== own_i || bus.d_rsp_valid !== !own_i ||
                    (own_i ? bus.i_rsp_rdata : bus.d_rsp_rdata) !== bus.m_rsp_rdata)
                    begin bad++; $display("FAIL collision_route g=%0d got iv=%b dv=%b want owner_i=%b", g,
                        bus.i_rsp_valid, bus.d_rsp_valid, own_i); end
            end
            if (bus.m_req_valid) begin
                total++;
                if (bus.m_addr !== exp_addr)
                    begin bad++; $display("FAIL collision_addr got %h want %h", bus.m_addr, exp_addr); end
            end
            if (bus.d_req_ready || bus.i_req_ready) begin
                total++;
                if (bus.i_req_ready !== (g % 3 == 2) || bus.d_req_ready !== (g % 3 != 2))
                    begin bad++; $display("FAIL collision_order g=%0d got i=%b d=%b want i=%b", g,
                        bus.i_req_ready, bus.d_req_ready, (g % 3 == 2)); end
                own_i = bus.i_req_ready;
                exp_addr = own_i ? bus.i_addr : bus.d_addr;
                g++;
            end
            mem_busy = bus.m_req_valid && bus.m_req_ready;
            cyc++;
            @(negedge clk);
        end
        total++;
        if (g < 12) begin bad++; $display("FAIL collision_budget got grants=%0d want 12", g); end
        idle_inputs();
    endtask

    task automatic test_write_backpressure();
        int n = 0;
        do_reset();
        bus.d_req_valid = 1'b1; bus.d_we = 1'b1; bus.d_wdata = 32'hCAFE_BABE; bus.d_be = 4'b0011;
        bus.d_addr = 32'h2000_0040; #1;
        total++;
        if (bus.d_req_ready !== 1'b1) begin bad++; $display("FAIL wr_accept got %b want 1", bus.d_req_ready); end
        @(negedge clk); idle_inputs();
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (bus.m_req_valid !== 1'b1 || bus.m_addr !== 32'h2000_0040 || bus.m_we !== 1'b1 ||
                bus.m_wdata !== 32'hCAFE_BABE || bus.m_be !== 4'b0011 || bus.d_req_ready !== 1'b0)
                begin bad++; $display("FAIL wr_stable cyc=%0d got v=%b a=%h we=%b wd=%h be=%b", c,
                    bus.m_req_valid, bus.m_addr, bus.m_we, bus.m_wdata, bus.m_be); end
            @(negedge clk);
        end
        bus.m_req_ready = 1'b1;
        @(negedge clk); bus.m_req_ready = 1'b0; bus.m_rsp_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.d_rsp_valid === 1'b1) n++;
            @(negedge clk); bus.m_rsp_valid = 1'b0;
        end
        total++;
        if (n != 1) begin bad++; $display("FAIL wr_rsp_count got %0d want 1", n); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        bus.d_req_valid = 1'b1; bus.d_addr = 32'h4000_0000; bus.m_req_ready = 1'b1;
        @(negedge clk); bus.d_req_valid = 1'b0;
        @(negedge clk); bus.m_req_ready = 1'b0; rst = 1'b1; #1;
        total++;
        if (bus.d_rsp_valid !== 1'b0 || bus.i_rsp_valid !== 1'b0)
            begin bad++; $display("FAIL rstwait_during got dv=%b iv=%b want 0 0", bus.d_rsp_valid, bus.i_rsp_valid); end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (bus.d_rsp_valid !== 1'b0 || bus.i_rsp_valid !== 1'b0 || bus.m_req_valid !== 1'b0)
                begin bad++; $display("FAIL rstwait_after cyc=%0d got dv=%b iv=%b mv=%b want 0", c,
                    bus.d_rsp_valid, bus.i_rsp_valid, bus.m_req_valid); end
            @(negedge clk);
        end
        bus.d_req_valid = 1'b1; #1;
        total++;
        if (bus.d_req_ready !== 1'b1) begin bad++; $display("FAIL rstwait_idle got rdy=%b want 1", bus.d_req_ready); end
        @(negedge clk); idle_inputs();
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        int hit = -1;
        do_reset();
        bus.d_req_valid = 1'b1; bus.d_addr = 32'h5000_0000; bus.m_req_ready = 1'b1;
        @(negedge clk); bus.d_req_valid = 1'b0;
        @(negedge clk); bus.m_req_ready = 1'b0;
        for (int c = 0; c < TMO + 4; c++) begin
            #1;
            if (bus.d_rsp_valid === 1'b1) begin
                n++; hit = c;
                total++;
                if (bus.d_rsp_err !== 1'b1 || bus.d_rsp_rdata !== '0 || bus.i_rsp_valid !== 1'b0)
                    begin bad++; $display("FAIL tmo_rsp got err=%b rd=%h iv=%b want 1 0 0",
                        bus.d_rsp_err, bus.d_rsp_rdata, bus.i_rsp_valid); end
            end
            @(negedge clk);
        end
        total++;
        if (n != 1 || hit != TMO - 1) begin bad++; $display("FAIL tmo_count got n=%0d at=%0d want 1 at %0d", n, hit, TMO - 1); end
        bus.d_req_valid = 1'b1; bus.d_addr = 32'h5000_0100; bus.m_req_ready = 1'b1;
        @(negedge clk); bus.d_req_valid = 1'b0;
        @(negedge clk); bus.m_req_ready = 1'b0; bus.m_rsp_valid = 1'b1; bus.m_rsp_rdata = 32'hDEAD_0000; #1;
        total++;
        if (bus.d_rsp_valid !== 1'b0 || bus.i_rsp_valid !== 1'b0)
            begin bad++; $display("FAIL tmo_late_drop got dv=%b iv=%b want 0 0", bus.d_rsp_valid, bus.i_rsp_valid); end
        @(negedge clk); bus.m_rsp_rdata = 32'h0000_1234; #1;
        total++;
        if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_rdata !== 32'h1234 || bus.d_rsp_err !== 1'b0)
            begin bad++; $display("FAIL tmo_next_read got dv=%b rd=%h err=%b want 1 00001234 0",
                bus.d_rsp_valid, bus.d_rsp_rdata, bus.d_rsp_err); end
        @(negedge clk); idle_inputs();
    endtask
`endif

    task automatic test_random(input int ncyc);
        logic d_pend = 1'b0, i_pend = 1'b0, i_v;
        logic [AW-1:0] da = '0, ia = '0, xa = '0;
        logic dwe = 1'b0, xwe = 1'b0;
        logic [DW-1:0] dwd = '0, xwd = '0;
        logic [BW-1:0] dbe = '0, xbe = '0;
        logic busy = 1'b0, issued = 1'b0, own_i = 1'b0, rsp, win_d, win_i;
        int streak = 0, wait_n = 0, dly = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (!d_pend && $urandom_range(3) != 0) begin
                d_pend = 1'b1; da = $urandom; dwe = 1'($urandom); dwd = $urandom; dbe = BW'($urandom);
            end
            if (!i_pend && $urandom_range(3) == 0) begin i_pend = 1'b1; ia = $urandom; end
            bus.d_req_valid = d_pend; bus.d_addr = da; bus.d_we = dwe; bus.d_wdata = dwd; bus.d_be = dbe;
            bus.i_req_valid = i_pend; bus.i_addr = ia;
            bus.m_req_ready = 1'($urandom);
            rsp = busy && issued && (wait_n >= dly);
            bus.m_rsp_valid = rsp; bus.m_rsp_rdata = $urandom;
            #1;
            win_d = !busy && d_pend && !(streak == 2 && i_pend);
            win_i = !busy && i_pend && !win_d;
            total++;
            if (bus.d_req_ready !== win_d || bus.i_req_ready !== win_i)
                begin bad++; $display("FAIL rnd_grant cyc=%0d got d=%b i=%b want d=%b i=%b", c,
                    bus.d_req_ready, bus.i_req_ready, win_d, win_i); end
            total++;
            if (bus.m_req_valid !== (busy && !issued) ||
                (busy && !issued && (bus.m_addr !== xa || bus.m_we !== xwe || bus.m_be !== xbe ||
                                     (!own_i && bus.m_wdata !== xwd))))
                begin bad++; $display("FAIL rnd_issue cyc=%0d got v=%b a=%h we=%b be=%h want v=%b a=%h we=%b be=%h", c,
                    bus.m_req_valid, bus.m_addr, bus.m_we, bus.m_be, busy && !issued, xa, xwe, xbe); end
            total++;
            if (bus.d_rsp_valid !== (rsp && !own_i) || bus.i_rsp_valid !== (rsp && own_i) ||
                bus.d_rsp_rdata !== ((rsp && !own_i) ? bus.m_rsp_rdata : '0) ||
                bus.i_rsp_rdata !== ((rsp && own_i) ? bus.m_rsp_rdata : '0) ||
                bus.d_rsp_err !== 1'b0 || bus.i_rsp_err !== 1'b0)
                begin bad++; $display("FAIL rnd_rsp cyc=%0d got dv=%b iv=%b drd=%h ird=%h want rsp=%b owner_i=%b", c,
                    bus.d_rsp_valid, bus.i_rsp_valid, bus.d_rsp_rdata, bus.i_rsp_rdata, rsp, own_i); end
            i_v = i_pend;
            if (rsp) busy = 1'b0;
            else if (busy && issued) wait_n++;
            if (busy && !issued && bus.m_req_ready) begin issued = 1'b1; wait_n = 0; dly = $urandom_range(3); end
            if (win_d || win_i) begin
                busy = 1'b1; issued = 1'b0; own_i = win_i;
                xa  = win_i ? ia : da;
                xwe = win_i ? 1'b0 : dwe;
                xwd = dwd;
                xbe = win_i ? '1 : dbe;
                if (win_d) d_pend = 1'b0; else i_pend = 1'b0;
            end
            if (win_d && i_v) streak = (streak < 3) ? streak + 1 : 3;
            else if (win_i || !i_v) streak = 0;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_collision();
        test_write_backpressure();
        test_reset_in_wait();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1000000");
        $fatal(1);
    end
endmodule
